// File: rtl/gate_bank_scheduler_if.sv
// Requester and response bundle for the shared gate-bank scheduler.
// Per-requester fields are packed side by side, requester i in slice i.
interface gate_bank_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IW-1:0]            rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/gate_bank_scheduler.sv
// Round-robin time-sharing of one 1-bit gate bank; operands go through it LSB first, one bit per cycle.
// Response WIDTH+1 cycles after the handshake (1 for illegal ops); one request in flight, RESP holds until rsp_ready.
module gate_bank_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    gate_bank_scheduler_if.slave bus,
    output logic                 gate_A,
    output logic                 gate_B,
    input  logic                 gate_and,
    input  logic                 gate_or,
    input  logic                 gate_nand,
    input  logic                 gate_xor,
    input  logic                 gate_not
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    rr_ptr, grant, id_q;
    logic [IW:0]      cand;
    logic             found, illegal, gate_bit, err_q;
    logic [2:0]       sel_op, op_q;
    logic [WIDTH-1:0] sel_a, sel_b, a_sh, b_sh, res, res_n;
    logic [CW-1:0]    bit_cnt;

    // Walk downward so the closest valid index at or after rr_ptr wins last.
    always_comb begin
        found = |bus.req_valid;
        grant = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (bus.req_valid[cand[IW-1:0]])
                grant = cand[IW-1:0];
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IW'(i)) begin
                sel_op = bus.req_op[3*i +: 3];
                sel_a  = bus.req_a[WIDTH*i +: WIDTH];
                sel_b  = bus.req_b[WIDTH*i +: WIDTH];
            end
        end
        illegal = (sel_op > 3'd4);
    end

    always_comb begin
        case (op_q)
            3'd0:    gate_bit = gate_and;
            3'd1:    gate_bit = gate_or;
            3'd2:    gate_bit = gate_nand;
            3'd3:    gate_bit = gate_xor;
            default: gate_bit = gate_not;
        endcase
        res_n = (res >> 1) | (WIDTH'(gate_bit) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = illegal ? RESP : SHIFT;
            SHIFT:   if (bit_cnt == CW'(WIDTH - 1)) state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            bit_cnt <= '0;
            err_q   <= 1'b0;
        end else if (state == IDLE && found) begin
            id_q    <= grant;
            op_q    <= sel_op;
            a_sh    <= sel_a;
            b_sh    <= sel_b;
            res     <= '0;
            bit_cnt <= '0;
            err_q   <= illegal;
            rr_ptr  <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
        end else if (state == SHIFT) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res     <= res_n;
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Response fields are forced to zero outside RESP so partial shift results never leak out.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found && !reset)
            bus.req_ready[grant] = 1'b1;
        gate_A        = (state == SHIFT) & a_sh[0];
        gate_B        = (state == SHIFT) & b_sh[0];
        bus.rsp_valid = (state == RESP);
        bus.rsp_id    = (state == RESP) ? id_q : '0;
        bus.rsp_data  = (state == RESP) ? res : '0;
        bus.rsp_err   = (state == RESP) & err_q;
    end
endmodule

// File: tb/tb_gate_bank_scheduler.sv
// Bench for gate_bank_scheduler: vector table, corner sequences, and randomized traffic vs a word-level model.
module tb_gate_bank_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_bank_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus();

    logic gate_A, gate_B, g_and, g_or, g_nand, g_xor, g_not;
    assign g_and  = gate_A & gate_B;
    assign g_or   = gate_A | gate_B;
    assign g_nand = ~(gate_A & gate_B);
    assign g_xor  = gate_A ^ gate_B;
    assign g_not  = ~gate_A;

    gate_bank_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .gate_A    (gate_A),
        .gate_B    (gate_B),
        .gate_and  (g_and),
        .gate_or   (g_or),
        .gate_nand (g_nand),
        .gate_xor  (g_xor),
        .gate_not  (g_not)
    );

    logic [N-1:0] valid_v;
    logic [2:0]   op_v [N];
    logic [W-1:0] a_v  [N];
    logic [W-1:0] b_v  [N];
    logic         rsp_rdy;

    always_comb begin
        bus.req_valid = valid_v;
        bus.rsp_ready = rsp_rdy;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_op[3*i +: 3] = op_v[i];
            bus.req_a[W*i +: W]  = a_v[i];
            bus.req_b[W*i +: W]  = b_v[i];
        end
    end

    int total = 0;
    int bad   = 0;
    int gate_busy = 0;
    int multi_ready = 0;

    always @(negedge clk) begin
        if (gate_A | gate_B) gate_busy++;
        if ($countones(bus.req_ready) > 1) multi_ready++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_word(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return a ^ b;
            3'd4:    return ~a;
            default: return '0;
        endcase
    endfunction

    // One full transaction: wait for a grant, time the response, optionally stall it, then accept.
    task automatic serve(input bit keep, input int hold, input int exp_gid,
                         input logic [W-1:0] exp_data, input logic exp_err);
        int gid, n, lat;
        gid = -1;
        n   = 0;
        rsp_rdy = 1'b0;
        while (gid < 0) begin
            #1;
            if (bus.req_ready != '0) begin
                chk("ready_onehot", $countones(bus.req_ready), 1);
                for (int i = 0; i < N; i++)
                    if (bus.req_ready[i]) gid = i;
            end else if (n >= 50) begin
                total++;
                bad++;
                $display("FAIL grant_timeout waited=%0d cycles required=grant", n);
                return;
            end else begin
                tick;
                n++;
            end
        end
        chk("grant_id", gid, exp_gid);
        tick;
        if (!keep) valid_v[gid] = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            tick;
            lat++;
        end
        chk("latency", lat, exp_err ? 1 : W + 1);
        chk("rsp_id", bus.rsp_id, exp_gid);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", bus.rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            tick;
            chk("rsp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data},
                {1'b1, 2'(exp_gid), exp_err, exp_data});
            chk("no_ready_in_resp", bus.req_ready, 0);
        end
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         err;
    } vec_t;

    vec_t vt [12];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g, model_rr, k, mask;
        vt[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vt[1]  = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        vt[2]  = '{3'd2, 8'hA5, 8'h0F, 8'hFA, 1'b0};
        vt[3]  = '{3'd3, 8'hA5, 8'h0F, 8'hAA, 1'b0};
        vt[4]  = '{3'd4, 8'hA5, 8'h0F, 8'h5A, 1'b0};
        vt[5]  = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        vt[6]  = '{3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vt[7]  = '{3'd2, 8'h00, 8'h00, 8'hFF, 1'b0};
        vt[8]  = '{3'd5, 8'h12, 8'h34, 8'h00, 1'b1};
        vt[9]  = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vt[10] = '{3'd1, 8'h80, 8'h01, 8'h81, 1'b0};
        vt[11] = '{3'd4, 8'h00, 8'hFF, 8'hFF, 1'b0};

        for (int i = 0; i < N; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
        end
        rsp_rdy = 1'b0;
        valid_v = '1;
        reset   = 1'b1;
        tick;
        tick;
        chk("reset_outputs", {bus.req_ready, gate_A, gate_B, bus.rsp_valid, bus.rsp_id,
                              bus.rsp_data, bus.rsp_err}, 0);
        valid_v = '0;
        reset   = 1'b0;
        tick;

        // Directed vectors, rotating the requester index.
        for (int v = 0; v < 12; v++) begin
            k = v % N;
            op_v[k] = vt[v].op;
            a_v[k]  = vt[v].a;
            b_v[k]  = vt[v].b;
            valid_v = N'(1) << k;
            serve(1'b0, 0, k, vt[v].data, vt[v].err);
        end

        // All requesters valid from reset: strict rotation.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_v[i] = 3'(i);
            a_v[i]  = 8'hA5;
            b_v[i]  = 8'h0F;
        end
        valid_v = '1;
        for (int g = 0; g < 6; g++)
            serve(1'b1, 0, g % N, ref_word(3'(g % N), 8'hA5, 8'h0F), 1'b0);
        chk("never_two_ready", multi_ready, 0);

        // Response stalled five cycles, then the next grant follows immediately.
        valid_v = '0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        op_v[0] = 3'd3; a_v[0] = 8'h5C; b_v[0] = 8'h33;
        op_v[1] = 3'd1; a_v[1] = 8'h10; b_v[1] = 8'h02;
        valid_v = 4'b0011;
        serve(1'b0, 5, 0, 8'h6F, 1'b0);
        #1;
        chk("grant_after_resp", bus.req_ready, 4'b0010);
        serve(1'b0, 0, 1, 8'h12, 1'b0);

        // Illegal opcode must not touch the gate pins.
        op_v[2] = 3'd6; a_v[2] = 8'hFF; b_v[2] = 8'hFF;
        valid_v = 4'b0100;
        gate_busy = 0;
        serve(1'b0, 0, 2, 8'h00, 1'b1);
        chk("gate_idle_on_illegal", gate_busy, 0);

        // Reset during bit 4 of a shift drops the request.
        op_v[0] = 3'd0; a_v[0] = 8'hFF; b_v[0] = 8'hFF;
        valid_v = 4'b0001;
        k = 0;
        #1;
        while (!bus.req_ready[0] && k < 50) begin
            tick;
            #1;
            k++;
        end
        chk("pre_reset_grant", bus.req_ready, 4'b0001);
        tick;
        valid_v = '0;
        repeat (4) tick;
        reset   = 1'b1;
        valid_v = 4'b1001;
        op_v[3] = 3'd1; a_v[3] = 8'h01; b_v[3] = 8'h02;
        op_v[0] = 3'd3; a_v[0] = 8'hF0; b_v[0] = 8'h0F;
        tick;
        chk("mid_shift_reset", {bus.req_ready, gate_A, gate_B, bus.rsp_valid, bus.rsp_id,
                                bus.rsp_data, bus.rsp_err}, 0);
        reset = 1'b0;
        #1;
        chk("no_rsp_after_reset", bus.rsp_valid, 0);
        chk("first_grant_lowest", bus.req_ready, 4'b0001);
        serve(1'b0, 0, 0, 8'hFF, 1'b0);
        serve(1'b0, 0, 3, 8'h03, 1'b0);

        // Randomized traffic against the round-robin model.
        valid_v = '0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_rr = 0;
        for (int t = 0; t < 40; t++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                op_v[i] = 3'($urandom_range(0, 7));
                a_v[i]  = W'($urandom);
                b_v[i]  = W'($urandom);
            end
            valid_v = N'(mask);
            exp_g = -1;
            for (int s = 0; s < N; s++)
                if (exp_g < 0 && mask[(model_rr + s) % N]) exp_g = (model_rr + s) % N;
            serve(1'b0, $urandom_range(0, 2), exp_g,
                  ref_word(op_v[exp_g], a_v[exp_g], b_v[exp_g]), op_v[exp_g] > 3'd4);
            model_rr = (exp_g + 1) % N;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
